// File: rtl/gl_pkg.sv
// ============================================================================
// Module      : gl_pkg
// Description : Shared framebuffer geometry, pixel-word layout and colour types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gl_pkg;

    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;
    localparam int ADDR_W_DEF = 19;

    localparam int Y_MSB = 88;
    localparam int Y_LSB = 80;
    localparam int X_MSB = 73;
    localparam int X_LSB = 64;
    localparam int R_MSB = 55;
    localparam int R_LSB = 50;
    localparam int G_MSB = 47;
    localparam int G_LSB = 42;
    localparam int B_MSB = 39;
    localparam int B_LSB = 34;

    localparam int Y_W = Y_MSB - Y_LSB + 1;
    localparam int X_W = X_MSB - X_LSB + 1;
    localparam int C_W = R_MSB - R_LSB + 1;

    typedef struct packed {
        logic [C_W-1:0] r;
        logic [C_W-1:0] g;
        logic [C_W-1:0] b;
    } rgb666_t;

    // Field order mirrors the bit positions above, pads included.
    typedef struct packed {
        logic [95:Y_MSB+1]      pad_hi;
        logic [Y_W-1:0]         y;
        logic [Y_LSB-1:X_MSB+1] pad_yx;
        logic [X_W-1:0]         x;
        logic [X_LSB-1:R_MSB+1] pad_xr;
        logic [C_W-1:0]         r;
        logic [R_LSB-1:G_MSB+1] pad_rg;
        logic [C_W-1:0]         g;
        logic [G_LSB-1:B_MSB+1] pad_gb;
        logic [C_W-1:0]         b;
        logic [B_LSB-1:0]       pad_lo;
    } pix_word_t;

endpackage

`default_nettype wire

// File: rtl/gl_fb_addr_gen.sv
// ============================================================================
// Module      : gl_fb_addr_gen
// Description : Combinational linear framebuffer address y*H_RES + x.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gl_fb_addr_gen
    import gl_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [Y_W-1:0]    i_y,
    input  logic [X_W-1:0]    i_x,
    output logic [ADDR_W-1:0] o_addr
);

    generate
        if (H_RES == 640) begin : g_h640
            // 640 = 512 + 128, so no multiplier is needed.
            assign o_addr = (ADDR_W'(i_y) << 9) + (ADDR_W'(i_y) << 7) + ADDR_W'(i_x);
        end else begin : g_generic
            assign o_addr = ADDR_W'(i_y) * ADDR_W'(H_RES) + ADDR_W'(i_x);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/gl_pixel_writer.sv
// ============================================================================
// Module      : gl_pixel_writer
// Description : Pops packed pixel words from the raster FIFO and writes them to
//               a linear framebuffer; also runs full-screen clears.
//               Optional bounds check: define GL_PIXEL_BOUNDS_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gl_pixel_writer
    import gl_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              empty,
    input  logic [95:0]       rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [17:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    input  logic              clear_req,
    input  logic [17:0]       clear_color,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [31:0]       pixel_count,
    output logic [15:0]       drop_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [ADDR_W-1:0] r_addr;
    rgb666_t           r_wdata;
    logic [31:0]       r_pixel_count;

    pix_word_t         w_word;
    logic [ADDR_W-1:0] w_pix_addr;
    logic              w_last;
    logic              w_drop;
    logic              w_unused;

    assign w_word   = rd_data;
    assign w_last   = (r_addr == c_LAST_ADDR);
    assign w_unused = ^{w_word.pad_hi, w_word.pad_yx, w_word.pad_xr,
                        w_word.pad_rg, w_word.pad_gb, w_word.pad_lo};

    gl_fb_addr_gen #(
        .H_RES  (H_RES),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_y    (w_word.y),
        .i_x    (w_word.x),
        .o_addr (w_pix_addr)
    );

`ifdef GL_PIXEL_BOUNDS_CHECK_EN
    logic [15:0] r_drop_count;

    assign w_drop = (32'(w_word.x) >= H_RES) || (32'(w_word.y) >= V_RES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if ((r_state == S_FETCH) && w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign w_drop     = 1'b0;
    assign drop_count = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_next = S_CLEAR;
                end else if (!empty) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // A dropped pixel re-enters through IDLE so a pending clear is seen.
                w_next = w_drop ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                if (mem_ready) begin
                    w_next = (!empty && !clear_req) ? S_FETCH : S_IDLE;
                end
            end
            S_CLEAR: begin
                if (mem_ready && w_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en      = 1'b0;
        mem_we     = 1'b0;
        clear_busy = 1'b0;
        clear_done = 1'b0;
        case (r_state)
            S_IDLE:  rd_en = rst_n && !clear_req && !empty;
            S_FETCH: ;
            S_WRITE: begin
                mem_we = 1'b1;
                rd_en  = mem_ready && !empty && !clear_req;
            end
            S_CLEAR: begin
                mem_we     = 1'b1;
                clear_busy = 1'b1;
                clear_done = mem_ready && w_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_pixel_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_req) begin
                        r_addr  <= '0;
                        r_wdata <= clear_color;
                    end
                end
                S_FETCH: begin
                    if (!w_drop) begin
                        r_addr  <= w_pix_addr;
                        r_wdata <= {w_word.r, w_word.g, w_word.b};
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        r_pixel_count <= r_pixel_count + 32'd1;
                    end
                end
                S_CLEAR: begin
                    if (mem_ready && !w_last) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign pixel_count = r_pixel_count;

endmodule

`default_nettype wire

// File: tb/tb_gl_pixel_writer.sv
// Testbench for gl_pixel_writer: 640x480 instance for pixel traffic,
// 4x2 instance for clear sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_gl_pixel_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 640x480 instance ----------------
    logic        rst_n_b;
    logic        empty_b;
    logic [95:0] rd_data_b = '0;
    logic        rd_en_b;
    logic [18:0] addr_b;
    logic [17:0] wdata_b;
    logic        we_b;
    logic        ready_b;
    logic        creq_b;
    logic [17:0] ccol_b;
    logic        busy_b;
    logic        done_b;
    logic [31:0] pcnt_b;
    logic [15:0] dcnt_b;

    gl_pixel_writer #(.H_RES(640), .V_RES(480), .ADDR_W(19)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n_b),
        .empty       (empty_b),
        .rd_data     (rd_data_b),
        .rd_en       (rd_en_b),
        .mem_addr    (addr_b),
        .mem_wdata   (wdata_b),
        .mem_we      (we_b),
        .mem_ready   (ready_b),
        .clear_req   (creq_b),
        .clear_color (ccol_b),
        .clear_busy  (busy_b),
        .clear_done  (done_b),
        .pixel_count (pcnt_b),
        .drop_count  (dcnt_b)
    );

    // ---------------- 4x2 instance ----------------
    logic        rst_n_s;
    logic        empty_s = 1'b1;
    logic [95:0] rd_data_s = '0;
    logic        rd_en_s;
    logic [2:0]  addr_s;
    logic [17:0] wdata_s;
    logic        we_s;
    logic        ready_s;
    logic        creq_s;
    logic [17:0] ccol_s;
    logic        busy_s;
    logic        done_s;
    logic [31:0] pcnt_s;
    logic [15:0] dcnt_s;

    gl_pixel_writer #(.H_RES(4), .V_RES(2), .ADDR_W(3)) u_dut_small (
        .clk         (clk),
        .rst_n       (rst_n_s),
        .empty       (empty_s),
        .rd_data     (rd_data_s),
        .rd_en       (rd_en_s),
        .mem_addr    (addr_s),
        .mem_wdata   (wdata_s),
        .mem_we      (we_s),
        .mem_ready   (ready_s),
        .clear_req   (creq_s),
        .clear_color (ccol_s),
        .clear_busy  (busy_s),
        .clear_done  (done_s),
        .pixel_count (pcnt_s),
        .drop_count  (dcnt_s)
    );

    // ---------------- FIFO model with 1-cycle read latency ----------------
    logic [95:0] fifo_mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty_b = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rd_en_b) begin
            rd_data_b <= fifo_mem[rd_ptr % 32];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // ---------------- monitors ----------------
    int          cyc = 0;
    int          nw_b = 0;
    int          nr_b = 0;
    int          bad_pop = 0;
    logic [18:0] wa_b [0:63];
    logic [17:0] wd_b [0:63];
    int          wc_b [0:63];
    int          rc_b [0:63];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we_b && ready_b && nw_b < 64) begin
            wa_b[nw_b] <= addr_b;
            wd_b[nw_b] <= wdata_b;
            wc_b[nw_b] <= cyc;
            nw_b       <= nw_b + 1;
        end
        if (rd_en_b) begin
            if (nr_b < 64) rc_b[nr_b] <= cyc;
            nr_b <= nr_b + 1;
            if (empty_b) bad_pop <= bad_pop + 1;
        end
    end

    int          nw_s = 0;
    int          ndone_s = 0;
    int          done_idx_s = -1;
    int          nbusy_s = 0;
    int          rd_s = 0;
    logic [2:0]  wa_s [0:31];
    logic [17:0] wd_s [0:31];
    int          wc_s [0:31];

    always @(posedge clk) begin
        if (we_s && ready_s && nw_s < 32) begin
            wa_s[nw_s] <= addr_s;
            wd_s[nw_s] <= wdata_s;
            wc_s[nw_s] <= cyc;
            nw_s       <= nw_s + 1;
            if (busy_s) nbusy_s <= nbusy_s + 1;
        end
        if (done_s) begin
            ndone_s    <= ndone_s + 1;
            done_idx_s <= nw_s;
        end
        if (rd_en_s) rd_s <= rd_s + 1;
    end

    // ---------------- checking helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] mkword(input logic [8:0] y, input logic [9:0] x,
                                           input logic [5:0] r, input logic [5:0] g,
                                           input logic [5:0] b, input bit junk);
        logic [95:0] w;
        w = junk ? {96{1'b1}} : '0;
        w[88:80] = y;
        w[73:64] = x;
        w[55:50] = r;
        w[47:42] = g;
        w[39:34] = b;
        return w;
    endfunction

    task automatic push(input logic [95:0] w);
        fifo_mem[wr_ptr % 32] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    typedef struct {
        logic [8:0]  y;
        logic [9:0]  x;
        logic [5:0]  r;
        logic [5:0]  g;
        logic [5:0]  b;
        logic [18:0] ea;
        logic [17:0] ed;
    } vec_t;

    vec_t tv [0:8];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before;
        tv[0] = '{9'd2,   10'd5,   6'h3F, 6'h00, 6'h15, 19'd1285,   18'h3F015};
        tv[1] = '{9'd0,   10'd0,   6'h00, 6'h00, 6'h00, 19'd0,      18'h00000};
        tv[2] = '{9'd0,   10'd639, 6'h3F, 6'h3F, 6'h3F, 19'd639,    18'h3FFFF};
        tv[3] = '{9'd1,   10'd0,   6'h01, 6'h02, 6'h03, 19'd640,    18'h01083};
        tv[4] = '{9'd479, 10'd639, 6'h2A, 6'h15, 6'h0C, 19'd307199, 18'h2A54C};
        tv[5] = '{9'd100, 10'd320, 6'h10, 6'h20, 6'h30, 19'd64320,  18'h10830};
        tv[6] = '{9'd300, 10'd1,   6'h00, 6'h3F, 6'h00, 19'd192001, 18'h00FC0};
        tv[7] = '{9'd7,   10'd7,   6'h05, 6'h0A, 6'h11, 19'd4487,   18'h05291};
        tv[8] = '{9'd50,  10'd639, 6'h00, 6'h00, 6'h01, 19'd32639,  18'h00001};

        rst_n_b = 1'b0; ready_b = 1'b1; creq_b = 1'b0; ccol_b = '0;
        rst_n_s = 1'b0; ready_s = 1'b1; creq_s = 1'b0; ccol_s = '0;
        repeat (3) @(negedge clk);
        rst_n_b = 1'b1;
        rst_n_s = 1'b1;
        @(negedge clk);

        // reset values
        chk("rst_rd_en",   64'(rd_en_b), 64'd0);
        chk("rst_mem_we",  64'(we_b),    64'd0);
        chk("rst_addr",    64'(addr_b),  64'd0);
        chk("rst_wdata",   64'(wdata_b), 64'd0);
        chk("rst_busy_done", 64'({busy_b, done_b}), 64'd0);
        chk("rst_counts",  64'({pcnt_b, dcnt_b}), 64'd0);

        // single pixel, latency
        push(mkword(tv[0].y, tv[0].x, tv[0].r, tv[0].g, tv[0].b, 1'b1));
        for (int k = 0; k < 20 && nw_b < 1; k++) @(negedge clk);
        chk("single_timeout", 64'(nw_b), 64'd1);
        chk("single_addr",    64'(wa_b[0]), 64'(tv[0].ea));
        chk("single_data",    64'(wd_b[0]), 64'(tv[0].ed));
        chk("single_latency", 64'(wc_b[0] - rc_b[0]), 64'd2);
        chk("single_pcount",  64'(pcnt_b), 64'd1);

        // 8 back-to-back words
        for (int i = 1; i <= 8; i++)
            push(mkword(tv[i].y, tv[i].x, tv[i].r, tv[i].g, tv[i].b, i[0]));
        for (int k = 0; k < 40 && nw_b < 9; k++) @(negedge clk);
        chk("burst_timeout", 64'(nw_b), 64'd9);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("burst_addr[%0d]", i), 64'(wa_b[i]), 64'(tv[i].ea));
            chk($sformatf("burst_data[%0d]", i), 64'(wd_b[i]), 64'(tv[i].ed));
            if (i >= 2)
                chk($sformatf("burst_gap[%0d]", i), 64'(wc_b[i] - wc_b[i-1]), 64'd2);
        end
        chk("burst_pcount", 64'(pcnt_b), 64'd9);

        // back-pressure: mem_ready low for 5 cycles
        ready_b = 1'b0;
        push(mkword(9'd3, 10'd3, 6'h01, 6'h01, 6'h01, 1'b0));
        push(mkword(9'd4, 10'd4, 6'h3F, 6'h3F, 6'h3F, 1'b0));
        for (int k = 0; k < 10 && !we_b; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("stall_we",    64'(we_b),    64'd1);
            chk("stall_addr",  64'(addr_b),  64'd1923);
            chk("stall_data",  64'(wdata_b), 64'h01041);
            chk("stall_rd_en", 64'(rd_en_b), 64'd0);
            @(negedge clk);
        end
        chk("stall_no_write", 64'(nw_b), 64'd9);
        ready_b = 1'b1;
        @(negedge clk);
        chk("release_one_write", 64'(nw_b), 64'd10);
        chk("release_addr",      64'(wa_b[9]), 64'd1923);
        for (int k = 0; k < 20 && nw_b < 11; k++) @(negedge clk);
        chk("after_stall_addr", 64'(wa_b[10]), 64'd2564);
        chk("after_stall_data", 64'(wd_b[10]), 64'h3FFFF);

        // out-of-range pixel x=700, y=10
        push(mkword(9'd10, 10'd700, 6'h01, 6'h01, 6'h01, 1'b0));
        repeat (12) @(negedge clk);
`ifdef GL_PIXEL_BOUNDS_CHECK_EN
        chk("oob_no_write",   64'(nw_b),   64'd11);
        chk("oob_drop_count", 64'(dcnt_b), 64'd1);
`else
        chk("oob_write",      64'(nw_b),     64'd12);
        chk("oob_addr",       64'(wa_b[11]), 64'd7100);
        chk("oob_drop_count", 64'(dcnt_b),   64'd0);
`endif
        chk("no_pop_when_empty", 64'(bad_pop), 64'd0);

        // clear on 4x2 framebuffer
        ccol_s = 18'h00FFF;
        creq_s = 1'b1;
        @(negedge clk);
        creq_s = 1'b0;
        ccol_s = 18'h3FFFF;
        chk("clear_busy_start", 64'(busy_s), 64'd1);
        for (int k = 0; k < 30 && ndone_s < 1; k++) @(negedge clk);
        chk("clear_writes", 64'(nw_s), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("clear_addr[%0d]", i), 64'(wa_s[i]), 64'(i));
            chk($sformatf("clear_data[%0d]", i), 64'(wd_s[i]), 64'h00FFF);
        end
        chk("clear_busy_all",   64'(nbusy_s),    64'd8);
        chk("clear_done_once",  64'(ndone_s),    64'd1);
        chk("clear_done_index", 64'(done_idx_s), 64'd7);
        chk("clear_span",       64'(wc_s[7] - wc_s[0]), 64'd7);
        chk("clear_no_fifo",    64'(rd_s),       64'd0);
        chk("clear_end_busy",   64'(busy_s),     64'd0);
        chk("clear_end_we",     64'(we_s),       64'd0);

        // reset during clear at address 3
        ccol_s = 18'h2AAAA;
        creq_s = 1'b1;
        @(negedge clk);
        creq_s = 1'b0;
        for (int k = 0; k < 20 && addr_s != 3'd3; k++) @(negedge clk);
        chk("abort_reached_addr3", 64'(addr_s), 64'd3);
        rst_n_s = 1'b0;
        #1;
        chk("abort_we",    64'(we_s),    64'd0);
        chk("abort_addr",  64'(addr_s),  64'd0);
        chk("abort_wdata", 64'(wdata_s), 64'd0);
        chk("abort_flags", 64'({busy_s, done_s, rd_en_s}), 64'd0);
        n_before = nw_s;
        repeat (2) @(negedge clk);
        rst_n_s = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_resume", 64'(nw_s),   64'(n_before));
        chk("abort_idle_busy", 64'(busy_s), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
